// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and elaboration-time parameter checks for the clock-divider sequencer.
package clk_div_ctrl_pkg;

    localparam int unsigned DIV_MIN_DEF = 2;

    typedef enum logic [3:0] {
        IDLE,
        REJECT,
        SAME,
        WAIT_TC,
        GATE_OFF,
        LOAD,
        SETTLE,
        ACK,
        WAIT_REL
    } state_e;

    function automatic bit params_ok(input int unsigned div_rst,
                                     input int unsigned div_min,
                                     input int unsigned gate_cyc);
        return (div_rst >= div_min) && (gate_cyc >= 1);
    endfunction

endpackage

// File: rtl/clk_div_ctrl_tmr.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module clk_div_ctrl_tmr #(
    parameter int unsigned W = 8
) (
    input  logic         clk_in,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Divide-ratio change sequencer: waits for terminal count, gates the divided clock,
// reloads the divider and ungates it so a ratio change never emits a runt pulse.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned DIV_RST  = 7,
    parameter int unsigned DIV_MIN  = DIV_MIN_DEF,
    parameter int unsigned GATE_CYC = 2,
    parameter int unsigned TO_CYC   = 255
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             req,
    input  logic [DIV_W-1:0] req_div,
    output logic             ack,
    output logic             err,
    output logic             busy,
    input  logic             div_tc,
    output logic [DIV_W-1:0] div_val,
    output logic             div_load,
    output logic             clk_en,
    output logic             tc_timeout
);

    localparam int unsigned TMR_MAX = (TO_CYC > GATE_CYC) ? TO_CYC : GATE_CYC;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_MIN_V = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TO_CYC - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYC - 1);

    generate
        if (!params_ok(DIV_RST, DIV_MIN, GATE_CYC)) begin : g_bad_params
            $error("clk_div_ctrl: DIV_RST must be >= DIV_MIN and GATE_CYC must be >= 1");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0] div_val_q, div_val_d;
    logic             clk_en_q, clk_en_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             div_load_q, div_load_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    clk_div_ctrl_tmr #(
        .W(TMR_W)
    ) u_tmr (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        tmo_d    = tmo_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    pend_d = req_div;
                    if (req_div < DIV_MIN_V) begin
                        state_d = REJECT;
                    end else if (req_div == div_val_q) begin
                        state_d = SAME;
                    end else begin
                        tmo_d    = 1'b0;
                        state_d  = WAIT_TC;
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                    end
                end
            end
            REJECT, SAME, ACK: state_d = WAIT_REL;
            WAIT_TC: begin
                if (div_tc || tmr_done) begin
                    tmo_d    = tmo_q | ~div_tc;
                    state_d  = GATE_OFF;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LOAD;
                end
            end
            GATE_OFF: if (tmr_done) state_d = LOAD;
            LOAD: begin
                state_d  = SETTLE;
                tmr_load = 1'b1;
                tmr_val  = GATE_LOAD;
            end
            SETTLE:   if (tmr_done) state_d = ACK;
            WAIT_REL: if (!req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Outputs are registered images of the state being entered, so they never glitch.
        ack_d      = (state_d == REJECT) || (state_d == SAME) || (state_d == ACK);
        err_d      = (state_d == REJECT);
        div_load_d = (state_d == LOAD);
        clk_en_d   = !((state_d == GATE_OFF) || (state_d == LOAD) || (state_d == SETTLE));
        busy_d     = !((state_d == IDLE) || (state_d == WAIT_REL));
        div_val_d  = (state_d == LOAD) ? pend_q : div_val_q;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            div_val_q  <= DIV_RST_V;
            clk_en_q   <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            div_load_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            div_val_q  <= div_val_d;
            clk_en_q   <= clk_en_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            div_load_q <= div_load_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
        end
    end

    assign ack        = ack_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign div_val    = div_val_q;
    assign div_load   = div_load_q;
    assign clk_en     = clk_en_q;
    assign tc_timeout = tmo_q;

endmodule
